led_finish_sequencer: RTL and testbench
=======================================

# led_finish_sequencer

Downstream consumer of the 0–150 step counter's `count_reached` flag. It synchronises that flag into the `clk` domain; the flag is generated on the button clock. On each rising edge of the flag it plays a timed sequence on the five board LEDs: a back-and-forth sweep ("scanner") followed by a flash burst. It replaces the free-running animation behind the counter with a triggered, bounded, retrigger-safe sequencer.

## Interface
- `STEP_CYCLES`, default 12_500_000: `clk` cycles each LED pattern is held (0.25 s at 50 MHz); legal range ≥ 2.
- `N_PASSES`, default 3: number of full sweep passes before the flash burst; legal range ≥ 1.
- `clk` input, 1 bit: system clock, rising edge.
- `reset` input, 1 bit: reset, asynchronous, active-high.
- `trigger` input, 1 bit: level from the counter (`count_reached`), asynchronous to `clk`.
- `led` output, 5 bits: LED pattern, active-high, registered.
- `busy` output, 1 bit: high while a sequence is playing, registered.

## Operation
- Synchroniser: two flops `s1 -> s2`, plus history flop `s3`. `start = s2 & ~s3`. All three flops clear on reset.
- Because `s3` clears on reset, a `trigger` held high across reset release produces exactly one `start`.
- FSM states: IDLE, SWEEP, FLASH.
- Registers:
  - step timer `tmr`, width `$clog2(STEP_CYCLES)`, counts 0..STEP_CYCLES-1.
  - sweep position `pos`, 0..7.
  - pass counter `pass`, 0..N_PASSES-1.
  - flash index `fl`, 0..3.
- IDLE: `led = 0`, `busy = 0`.
  - On `start`: go to SWEEP with `tmr = pos = pass = 0`, `led = 5'b00001`, `busy = 1`.
- SWEEP: positions 0..7 map to LED bit index 0,1,2,3,4,3,2,1, one-hot.
  - When `tmr == STEP_CYCLES-1`: `tmr` returns to 0 and `pos` increments.
  - When `pos == 7` wraps to 0, `pass` increments.
  - After the last position of pass N_PASSES-1: go to FLASH with `fl = 0`.
- FLASH: `fl` 0..3 maps to patterns 11111, 00000, 11111, 00000, each held STEP_CYCLES.
  - After `fl == 3` expires: go to IDLE; `led = 0` and `busy = 0` on the same edge.
- `start` while `busy` is ignored. There is no queueing and no restart; the running sequence is unaffected.
- `trigger` falling has no effect.
- `led` is never all-zero during SWEEP and is exactly one-hot there.
- Reset mid-sequence: all outputs and registers go to 0 immediately (asynchronous). The sequence is abandoned and does not resume.

## Timing
- Reset values: `led = 5'b00000`, `busy = 0`, FSM = IDLE, all counters 0.
- Trigger latency (from `trigger` sampled high by `s1` at edge E0):
  - `s2 = 1` after E1.
  - FSM enters SWEEP and `led = 00001`, `busy = 1` after E2.
  - Worst case including async sampling uncertainty: 3 `clk` edges.
- Each pattern is held exactly STEP_CYCLES cycles. No pattern is shortened or skipped, including the first.
- Total `busy` duration: `(8*N_PASSES + 4) * STEP_CYCLES` cycles.
  - Defaults: 28 × 12.5 M = 350 M cycles = 7 s.
- Earliest re-accept: the first `clk` edge after `busy` falls. `start` must still be a fresh rising edge.
  - A level held high throughout the sequence does not retrigger.
- Minimum `trigger` high pulse to be guaranteed seen: 2 `clk` periods.

## Test plan
Bench uses STEP_CYCLES=4 and N_PASSES=1, giving a 48-cycle sequence.
- Reset then idle:
  - Stimulus: assert `reset` mid-cycle, hold `trigger = 0`.
  - Required: `led = 0` and `busy = 0` immediately, staying there for 100 cycles after release.
- Single trigger:
  - Stimulus: raise `trigger` and keep it high.
  - Required: `led` reads 00001, 00010, 00100, 01000, 10000, 01000, 00100, 00010, each for exactly 4 cycles.
  - Then 11111, 00000, 11111, 00000, each for 4 cycles.
  - Then IDLE; `busy` was high for exactly 48 cycles. The held level causes no second run.
- Retrigger ignored:
  - Stimulus: pulse `trigger` at cycle 10 of a run.
  - Required: the sequence is identical to the single-trigger case, with `busy` falling at cycle 48.
- Back-to-back runs:
  - Stimulus: drop `trigger`, then raise it again 1 cycle after `busy` falls.
  - Required: a second full 48-cycle run starting after 2–3 edges.
- Reset mid-run:
  - Stimulus: assert `reset` during FLASH.
  - Required: `led = 0` and `busy = 0` asynchronously.
  - With `trigger` still high at release: exactly one new run starts 3 edges later.
- Short pulse:
  - Stimulus: a 2-cycle `trigger` pulse, asynchronous phase.
  - Required: exactly one run. A 0.5-cycle glitch may produce either zero runs or one complete run, never a partial run.

Source files
------------

// File: rtl/led_finish_sequencer_if.sv
// Connects the counter's finish flag to the LED sequencer and returns the LED pattern and busy status.
// The master drives the trigger; the slave owns the LED outputs.
interface led_finish_sequencer_if;
  logic       trigger;
  logic [4:0] led;
  logic       busy;

  modport master (output trigger, input led, input busy);
  modport slave  (input trigger, output led, output busy);
endinterface

// File: rtl/led_finish_sequencer.sv
// Triggered LED finish animation: a one-hot back-and-forth sweep, then a four-step flash burst.
// The asynchronous trigger level is synchronised, and only its rising edge starts a sequence while idle.
module led_finish_sequencer #(
  parameter int STEP_CYCLES = 12_500_000,
  parameter int N_PASSES    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  led_finish_sequencer_if.slave bus
);

  localparam int TW = $clog2(STEP_CYCLES);
  localparam int PW = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;
  localparam logic [TW-1:0] TMR_LAST  = TW'(STEP_CYCLES - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(N_PASSES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_FLASH} state_t;

  state_t          r_state, w_state_nxt;
  logic [TW-1:0]   r_tmr,   w_tmr_nxt;
  logic [2:0]      r_pos,   w_pos_nxt;
  logic [PW-1:0]   r_pass,  w_pass_nxt;
  logic [1:0]      r_fl,    w_fl_nxt;
  logic [4:0]      r_led,   w_led_nxt;
  logic            r_busy,  w_busy_nxt;
  logic            r_s1, r_s2, r_s3;
  logic            w_start;
  logic            w_step_done;

  // Positions 0..7 bounce across bit indices 0,1,2,3,4,3,2,1.
  function automatic logic [4:0] sweep_led(input logic [2:0] p);
    logic [2:0] idx;
    idx = (p <= 3'd4) ? p : 3'(4'd8 - {1'b0, p});
    return 5'b00001 << idx;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= bus.trigger;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // History flop clears on reset, so a level held across reset release yields one start.
  assign w_start     = r_s2 & ~r_s3;
  assign w_step_done = (r_tmr == TMR_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
      r_pos   <= '0;
      r_pass  <= '0;
      r_fl    <= '0;
      r_led   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_pos   <= w_pos_nxt;
      r_pass  <= w_pass_nxt;
      r_fl    <= w_fl_nxt;
      r_led   <= w_led_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_pos_nxt   = r_pos;
    w_pass_nxt  = r_pass;
    w_fl_nxt    = r_fl;
    w_led_nxt   = r_led;
    w_busy_nxt  = r_busy;

    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_SWEEP;
          w_tmr_nxt   = '0;
          w_pos_nxt   = '0;
          w_pass_nxt  = '0;
          w_led_nxt   = 5'b00001;
          w_busy_nxt  = 1'b1;
        end
      end

      ST_SWEEP: begin
        if (w_step_done) begin
          w_tmr_nxt = '0;
          if (r_pos == 3'd7) begin
            w_pos_nxt = '0;
            if (r_pass == PASS_LAST) begin
              w_state_nxt = ST_FLASH;
              w_pass_nxt  = '0;
              w_fl_nxt    = '0;
              w_led_nxt   = 5'b11111;
            end else begin
              w_pass_nxt = r_pass + 1'b1;
              w_led_nxt  = 5'b00001;
            end
          end else begin
            w_pos_nxt = r_pos + 3'd1;
            w_led_nxt = sweep_led(r_pos + 3'd1);
          end
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end

      ST_FLASH: begin
        if (w_step_done) begin
          w_tmr_nxt = '0;
          if (r_fl == 2'd3) begin
            w_state_nxt = ST_IDLE;
            w_fl_nxt    = '0;
            w_led_nxt   = 5'b00000;
            w_busy_nxt  = 1'b0;
          end else begin
            // Even flash steps are lit; the step being entered is r_fl+1.
            w_fl_nxt  = r_fl + 2'd1;
            w_led_nxt = r_fl[0] ? 5'b11111 : 5'b00000;
          end
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_led_nxt   = 5'b00000;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.led  = r_led;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_led_finish_sequencer.sv
// Directed bench for led_finish_sequencer with STEP_CYCLES=4, N_PASSES=1 (48-cycle runs).
// A trigger-history model predicts led/busy on every cycle; literal pattern tables pin the model.
module tb_led_finish_sequencer;

  localparam int STEP    = 4;
  localparam int NP      = 1;
  localparam int RUN_LEN = (8 * NP + 4) * STEP;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  led_finish_sequencer_if bus ();

  led_finish_sequencer #(
    .STEP_CYCLES(STEP),
    .N_PASSES   (NP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-written pattern per 4-cycle step for a single-pass run.
  logic [4:0] pat [12] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h08, 5'h04, 5'h02,
                           5'h1f, 5'h00, 5'h1f, 5'h00};

  // Model: a run starts on the edge after the trigger history shows a fresh rise two
  // samples back, then led/busy are a pure function of the cycle offset within the run.
  logic h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
  int   run_off = -1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      h1      <= 1'b0;
      h2      <= 1'b0;
      h3      <= 1'b0;
      run_off <= -1;
    end else begin
      if (run_off >= 0)
        run_off <= (run_off + 1 == RUN_LEN) ? -1 : run_off + 1;
      else if (h2 && !h3)
        run_off <= 0;
      h3 <= h2;
      h2 <= h1;
      h1 <= bus.trigger;
    end
  end

  function automatic logic [4:0] exp_led(input int off);
    int k;
    int p;
    if (off < 0) return 5'h00;
    k = off / STEP;
    if (k < 8 * NP) begin
      p = k % 8;
      if (p > 4) p = 8 - p;
      return 5'(1 << p);
    end
    return (((k - 8 * NP) % 2) == 0) ? 5'h1f : 5'h00;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      check("model_led",  {27'd0, bus.led},  {27'd0, exp_led(run_off)});
      check("model_busy", {31'd0, bus.busy}, {31'd0, (run_off >= 0)});
    end
  end

  // Counts edges until busy is seen high, sampling 1 time unit after each edge.
  task automatic wait_busy_rise(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy) seen = 1'b1;
    end
    if (!seen) lat = -1;
  endtask

  // Entered at edge+1 of the first busy cycle; checks all 48 cycles against the literal table.
  task automatic play_run(input int pulse_at, input int drop_at, input string tag);
    int bad_led;
    int bad_busy;
    bad_led  = 0;
    bad_busy = 0;
    for (int i = 0; i < RUN_LEN; i++) begin
      if (bus.led !== pat[i / STEP]) bad_led++;
      if (bus.busy !== 1'b1) bad_busy++;
      if (i == drop_at)      bus.trigger = 1'b0;
      if (i == pulse_at)     bus.trigger = 1'b1;
      if (i == pulse_at + 2) bus.trigger = 1'b0;
      @(posedge clk);
      #1;
    end
    check({tag, "_led_cycles_wrong"},  bad_led,  0);
    check({tag, "_busy_cycles_low"},   bad_busy, 0);
    check({tag, "_busy_after_48"},     {31'd0, bus.busy}, 0);
    check({tag, "_led_after_48"},      {27'd0, bus.led},  0);
  endtask

  task automatic idle_window(input int n, input string tag);
    int hits;
    hits = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.busy !== 1'b0 || bus.led !== 5'h00) hits++;
    end
    check(tag, hits, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    int bc;
    bus.trigger = 1'b0;
    reset       = 1'b1;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    repeat (5) @(posedge clk);

    // Reset asserted mid-cycle clears outputs without waiting for an edge.
    #3 reset = 1'b1;
    #1;
    check("reset_led",  {27'd0, bus.led},  0);
    check("reset_busy", {31'd0, bus.busy}, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    idle_window(100, "idle_after_reset");

    // Single trigger, held high.
    @(posedge clk);
    #3 bus.trigger = 1'b1;
    wait_busy_rise(lat);
    check("single_latency", lat, 3);
    play_run(-1, -1, "single");
    idle_window(60, "held_level_no_rerun");

    // Fresh pulse at cycle 10 of a run is ignored.
    #2 bus.trigger = 1'b0;
    repeat (5) @(posedge clk);
    #3 bus.trigger = 1'b1;
    wait_busy_rise(lat);
    check("retrig_latency", lat, 3);
    play_run(10, 6, "retrigger");

    // Back-to-back: raise again one cycle after busy falls.
    @(posedge clk);
    #1 bus.trigger = 1'b1;
    wait_busy_rise(lat);
    check("b2b_latency_2_to_3", {31'd0, (lat >= 2 && lat <= 3)}, 1);
    play_run(-1, 5, "back_to_back");

    // Reset during FLASH with trigger held high across release.
    #2 bus.trigger = 1'b1;
    wait_busy_rise(lat);
    check("pre_reset_latency", lat, 3);
    repeat (36) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrun_reset_led",  {27'd0, bus.led},  0);
    check("midrun_reset_busy", {31'd0, bus.busy}, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    wait_busy_rise(lat);
    check("post_reset_latency", lat, 3);
    play_run(-1, -1, "post_reset");
    idle_window(30, "post_reset_single_run");

    // Two-cycle pulse: rises at edge+4, falls 20 later, so two edges sample it high.
    #2 bus.trigger = 1'b0;
    repeat (5) @(posedge clk);
    #4 bus.trigger = 1'b1;
    #20 bus.trigger = 1'b0;
    wait_busy_rise(lat);
    check("short_pulse_seen", lat, 1);
    play_run(-1, -1, "short_pulse");
    idle_window(20, "short_pulse_single_run");

    // Half-cycle glitch between edges: zero runs or one complete run.
    @(posedge clk);
    #2 bus.trigger = 1'b1;
    #5 bus.trigger = 1'b0;
    bc = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (bus.busy) bc++;
    end
    check("glitch_whole_or_none", {31'd0, (bc == 0 || bc == RUN_LEN)}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
